credit_hit_scorer: RTL and testbench



---
 rtl/credit_hit_scorer.sv | 149 ++++++++++++++
 tb/tb_credit_hit_scorer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/credit_hit_scorer.sv
// rtl/credit_hit_scorer.sv - turns ball/credit collision pixels into at most one BCD-scored hit per frame
module credit_hit_scorer #(
    parameter int SCORE_DIGITS    = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAX_INDEX       = 15
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        gameRestart,
    input  logic        collisionBallCredit,
    input  logic [3:0]  creditIndex,
    input  logic [3:0]  creditValue,
    output logic [15:0] score,
    output logic        hitPulse,
    output logic [3:0]  hitIndex
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [15:0]    score_q, score_d;
    logic [CW-1:0]  cool_q, cool_d;
    logic           latch_valid_q, latch_valid_d;
    logic [3:0]     latch_idx_q, latch_idx_d;
    logic [3:0]     latch_val_q, latch_val_d;
    logic [3:0]     addend_q, addend_d;
    logic [3:0]     commit_idx_q, commit_idx_d;
    logic [3:0]     hit_index_q, hit_index_d;
    logic [1:0]     ptr_q, ptr_d;
    logic           carry_q, carry_d;

    logic           start_add;
    logic           last_digit;
    logic           idx_ok;
    logic [3:0]     digit_cur;
    logic [4:0]     digit_sum;
    logic [4:0]     digit_fix;

    assign start_add  = startOfFrame && latch_valid_q && (cool_q == '0) && (state_q == S_IDLE);
    assign last_digit = (ptr_q == 2'(SCORE_DIGITS - 1));
    assign idx_ok     = ({1'b0, creditIndex} <= 5'(MAX_INDEX));
    assign digit_cur  = score_q[{ptr_q, 2'b00} +: 4];
    assign digit_sum  = {1'b0, digit_cur} + ((ptr_q == 2'd0) ? {1'b0, addend_q} : 5'd0) + {4'd0, carry_q};
    assign digit_fix  = (digit_sum > 5'd9) ? (digit_sum - 5'd10) : digit_sum;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_add) state_d = S_ADD;
            S_ADD:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (gameRestart) state_d = S_IDLE;
    end

    always_comb begin
        hitPulse = (state_q == S_DONE);
    end

    always_comb begin
        score_d       = score_q;
        cool_d        = cool_q;
        latch_valid_d = latch_valid_q;
        latch_idx_d   = latch_idx_q;
        latch_val_d   = latch_val_q;
        addend_d      = addend_q;
        commit_idx_d  = commit_idx_q;
        hit_index_d   = hit_index_q;
        ptr_d         = ptr_q;
        carry_d       = carry_q;

        if (state_q == S_ADD) begin
            // A carry out of the top digit means the score overflowed; pin it at the maximum.
            if (last_digit && digit_sum > 5'd9) begin
                score_d = 16'h9999;
            end else begin
                score_d[{ptr_q, 2'b00} +: 4] = digit_fix[3:0];
            end
            carry_d = (digit_sum > 5'd9);
            ptr_d   = ptr_q + 2'd1;
            if (last_digit) hit_index_d = commit_idx_q;
        end

        if (startOfFrame) begin
            if (start_add) begin
                addend_d     = latch_val_q;
                commit_idx_d = latch_idx_q;
                ptr_d        = 2'd0;
                carry_d      = 1'b0;
                cool_d       = CW'(COOLDOWN_FRAMES);
            end else if (cool_q != '0) begin
                cool_d = cool_q - 1'b1;
            end
            latch_valid_d = 1'b0;
        end

        // The boundary clear above runs first so a collision on the startOfFrame pixel opens the new frame.
        if (collisionBallCredit && idx_ok && (!latch_valid_q || startOfFrame)) begin
            latch_valid_d = 1'b1;
            latch_idx_d   = creditIndex;
            latch_val_d   = (creditValue > 4'd9) ? 4'd9 : creditValue;
        end

        if (gameRestart) begin
            score_d       = '0;
            cool_d        = '0;
            latch_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_q       <= '0;
            cool_q        <= '0;
            latch_valid_q <= 1'b0;
            latch_idx_q   <= '0;
            latch_val_q   <= '0;
            addend_q      <= '0;
            commit_idx_q  <= '0;
            hit_index_q   <= '0;
            ptr_q         <= '0;
            carry_q       <= 1'b0;
        end else begin
            score_q       <= score_d;
            cool_q        <= cool_d;
            latch_valid_q <= latch_valid_d;
            latch_idx_q   <= latch_idx_d;
            latch_val_q   <= latch_val_d;
            addend_q      <= addend_d;
            commit_idx_q  <= commit_idx_d;
            hit_index_q   <= hit_index_d;
            ptr_q         <= ptr_d;
            carry_q       <= carry_d;
        end
    end

    assign score    = score_q;
    assign hitIndex = hit_index_q;

endmodule

// File: tb/tb_credit_hit_scorer.sv
// tb/tb_credit_hit_scorer.sv - directed and random checks of credit_hit_scorer against a frame-level score model
module tb_credit_hit_scorer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        gameRestart;
    logic        collisionBallCredit;
    logic [3:0]  creditIndex;
    logic [3:0]  creditValue;
    logic [15:0] score;
    logic        hitPulse;
    logic [3:0]  hitIndex;

    int checks   = 0;
    int failures = 0;

    // Reference: decimal score, frame cooldown, first-pixel latch, and how many cycles since a hit was accepted.
    int         m_score;
    int         m_cool;
    int         m_phase;
    int         m_cval;
    logic       m_lv;
    logic [3:0] m_lidx, m_lval, m_cidx, m_hidx;

    credit_hit_scorer dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .gameRestart        (gameRestart),
        .collisionBallCredit(collisionBallCredit),
        .creditIndex        (creditIndex),
        .creditValue        (creditValue),
        .score              (score),
        .hitPulse           (hitPulse),
        .hitIndex           (hitIndex)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_cool = 0; m_phase = 0; m_cval = 0;
        m_lv = 1'b0; m_lidx = '0; m_lval = '0; m_cidx = '0; m_hidx = '0;
    endtask

    task automatic model_edge();
        int ph;
        ph = m_phase;
        if (gameRestart) begin
            m_score = 0; m_cool = 0; m_lv = 1'b0; m_phase = 0;
        end else begin
            if (m_phase == 4) begin
                m_score = (m_score + m_cval > 9999) ? 9999 : m_score + m_cval;
                m_hidx  = m_cidx;
                m_phase = 5;
            end else if (m_phase == 5) begin
                m_phase = 0;
            end else if (m_phase > 0) begin
                m_phase++;
            end
            if (startOfFrame) begin
                if (m_lv && m_cool == 0 && ph == 0) begin
                    m_phase = 1; m_cval = int'(m_lval); m_cidx = m_lidx; m_cool = 8;
                end else if (m_cool > 0) begin
                    m_cool--;
                end
                m_lv = 1'b0;
            end
            if (collisionBallCredit && !m_lv) begin
                m_lv = 1'b1; m_lidx = creditIndex;
                m_lval = (creditValue > 4'd9) ? 4'd9 : creditValue;
            end
        end
    endtask

    task automatic step(input logic sof, input logic coll, input logic [3:0] idx,
                        input logic [3:0] val, input logic rst);
        @(negedge clk);
        startOfFrame = sof; collisionBallCredit = coll; creditIndex = idx;
        creditValue = val; gameRestart = rst;
        @(posedge clk);
        model_edge();
        #1;
        chk("hitPulse", 16'(hitPulse), 16'(m_phase == 5));
        chk("hitIndex", 16'(hitIndex), 16'(m_hidx));
        if (m_phase == 0 || m_phase == 5) chk("score", score, to_bcd(m_score));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic settle();
        for (int g = 0; g < 30; g++) begin
            if (m_cool > 0) step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
            else if (m_phase != 0) idle();
            else break;
        end
    endtask

    // Leaves the bench in the DONE cycle of the new hit.
    task automatic score_hit(input logic [3:0] idx, input logic [3:0] val);
        settle();
        step(1'b0, 1'b1, idx, val, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (4) idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        startOfFrame = 1'b0; collisionBallCredit = 1'b0; gameRestart = 1'b0;
        #1;
        model_reset();
        chk("rst_score", score, 16'h0000);
        chk("rst_pulse", 16'(hitPulse), 16'h0000);
        chk("rst_index", 16'(hitIndex), 16'h0000);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; gameRestart = 1'b0;
        collisionBallCredit = 1'b0; creditIndex = '0; creditValue = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_score", score, 16'h0000);
        chk("reset_pulse", 16'(hitPulse), 16'h0000);
        chk("reset_index", 16'(hitIndex), 16'h0000);
        @(negedge clk);
        resetN = 1'b1;

        score_hit(4'd3, 4'd7);
        chk("first_score", score, 16'h0007);
        chk("first_pulse", 16'(hitPulse), 16'h0001);
        chk("first_index", 16'(hitIndex), 16'h0003);
        idle();
        chk("pulse_one_cycle", 16'(hitPulse), 16'h0000);

        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        repeat (10) score_hit(4'd1, 4'd9);
        score_hit(4'd1, 4'd5);
        chk("score_95", score, 16'h0095);
        score_hit(4'd4, 4'd8);
        chk("carry_chain", score, 16'h0103);

        settle();
        step(1'b0, 1'b1, 4'd2, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd5, 4'd4, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (4) idle();
        chk("first_pixel_idx", 16'(hitIndex), 16'h0002);
        chk("first_pixel_score", score, 16'h0104);
        for (int f = 0; f < 8; f++) begin
            step(1'b0, 1'b1, 4'd7, 4'd3, 1'b0);
            step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        end
        repeat (5) idle();
        chk("cooldown_score", score, 16'h0104);
        chk("cooldown_index", 16'(hitIndex), 16'h0002);
        step(1'b0, 1'b1, 4'd9, 4'd2, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (4) idle();
        chk("frame9_score", score, 16'h0106);
        chk("frame9_index", 16'(hitIndex), 16'h0009);

        settle();
        step(1'b1, 1'b1, 4'd6, 4'd4, 1'b0);
        repeat (5) idle();
        chk("coincident_not_now", score, 16'h0106);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (4) idle();
        chk("coincident_score", score, 16'h0110);
        chk("coincident_index", 16'(hitIndex), 16'h0006);

        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        repeat (1110) score_hit(4'd11, 4'd9);
        score_hit(4'd12, 4'd5);
        chk("score_9995", score, 16'h9995);
        score_hit(4'd13, 4'd9);
        chk("saturate", score, 16'h9999);

        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        repeat (4) score_hit(4'd1, 4'd9);
        score_hit(4'd10, 4'd6);
        chk("score_42", score, 16'h0042);
        settle();
        step(1'b0, 1'b1, 4'd4, 4'd5, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        idle();
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
        chk("restart_score", score, 16'h0000);
        repeat (4) begin
            idle();
            chk("restart_no_pulse", 16'(hitPulse), 16'h0000);
        end
        chk("restart_keeps_index", 16'(hitIndex), 16'h000a);
        step(1'b0, 1'b1, 4'd8, 4'd3, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        repeat (4) idle();
        chk("after_restart_score", score, 16'h0003);
        chk("after_restart_index", 16'(hitIndex), 16'h0008);

        settle();
        step(1'b0, 1'b1, 4'd1, 4'd5, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        idle();
        do_reset();
        repeat (6) idle();
        chk("midadd_reset_score", score, 16'h0000);
        score_hit(4'd2, 4'd12);
        chk("clamp_score", score, 16'h0009);
        chk("clamp_index", 16'(hitIndex), 16'h0002);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 5) == 0, ($urandom % 3) == 0, 4'($urandom), 4'($urandom),
                 ($urandom % 80) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
